// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg
//   Shared definitions for the character-LCD write sequencer: FSM state
//   encodings, power-on init ROM length and byte constants, the clear/home
//   detect mask and small helper functions.
package lcd_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_PWR_WAIT,
      ST_LOAD,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_EXEC,
      ST_IDLE
   } state_t;

   localparam int          INIT_LEN      = 6;
   localparam logic [7:0]  LCD_FUNC_SET  = 8'h38;
   localparam logic [7:0]  LCD_DISP_ON   = 8'h0C;
   localparam logic [7:0]  LCD_CLEAR     = 8'h01;
   localparam logic [7:0]  LCD_ENTRY     = 8'h06;
   // Commands whose upper six bits are zero (0x01/0x02/0x03) need the long wait.
   localparam logic [7:0]  CLR_HOME_MASK = 8'hFC;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic is_clr_home(input logic rs, input logic [7:0] d);
      return !rs && ((d & CLR_HOME_MASK) == 8'h00);
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer
//   Loadable down-counter shared by every timed state of lcd_ctrl.
//   Loading N makes 'done' assert on the Nth cycle after the load edge, so a
//   state that loads N on entry and leaves on 'done' lasts exactly N cycles.
// Ports
//   clk, rst   clock / async active-high reset (counter resets to RST_VAL)
//   load       load strobe (wins over counting)
//   load_val   value to load
//   done       counter has reached 1 (last cycle of the interval)
module lcd_timer #(
   parameter int             CW      = 8,
   parameter logic [CW-1:0]  RST_VAL = '0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [CW-1:0]  load_val,
   output logic           done
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              cnt <= RST_VAL;
      else if (load)        cnt <= load_val;
      else if (cnt != '0)   cnt <= cnt - 1'b1;
   end

   assign done = (cnt == CW'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl
//   Write-only sequencer for an HD44780-style character LCD. After reset it
//   waits T_POWERON cycles, runs the 6-entry init ROM, then accepts one byte
//   at a time over valid/ready and generates setup / enable / hold / execute
//   timing for each write.
// Ports
//   clk, rst            clock / async active-high reset
//   req_valid/ready     byte handshake (transfer on valid & ready)
//   req_rs, req_data    register select (0 cmd, 1 data) and byte
//   init_done           sticky init-complete flag
//   lcd_data/rs/rw/en   LCD bus (rw tied low)
module lcd_ctrl
   import lcd_ctrl_pkg::*;
#(
   parameter int T_POWERON = 750000,
   parameter int T_AS      = 3,
   parameter int T_PW      = 12,
   parameter int T_AH      = 2,
   parameter int T_EXEC    = 2500,
   parameter int T_CLEAR   = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_rs,
   input  logic [7:0]  req_data,
   output logic        req_ready,
   output logic        init_done,
   output logic [7:0]  lcd_data,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        lcd_en
);

   localparam int T_MAX = imax(imax(imax(T_POWERON, T_AS), imax(T_PW, T_AH)),
                               imax(T_EXEC, T_CLEAR));
   localparam int CW    = $clog2(T_MAX + 1);

   state_t         state;
   logic [2:0]     init_idx;
   logic [7:0]     req_byte;
   logic           req_rs_q;
   logic           tmr_ld;
   logic [CW-1:0]  tmr_val;
   logic           tmr_done;

   function automatic logic [7:0] init_rom(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd2: return LCD_FUNC_SET;
         3'd3:             return LCD_DISP_ON;
         3'd4:             return LCD_CLEAR;
         3'd5:             return LCD_ENTRY;
         default:          return LCD_FUNC_SET;
      endcase
   endfunction

   // Each timed state is entered with the timer loaded to its length; the
   // load happens on the edge that leaves the previous state.
   always_comb begin
      tmr_ld  = 1'b0;
      tmr_val = '0;
      case (state)
         ST_LOAD:  begin tmr_ld = 1'b1;     tmr_val = CW'(T_AS); end
         ST_SETUP: begin tmr_ld = tmr_done; tmr_val = CW'(T_PW); end
         ST_PULSE: begin tmr_ld = tmr_done; tmr_val = CW'(T_AH); end
         // lcd_rs/lcd_data already hold the byte being executed
         ST_HOLD:  begin
            tmr_ld  = tmr_done;
            tmr_val = is_clr_home(lcd_rs, lcd_data) ? CW'(T_CLEAR) : CW'(T_EXEC);
         end
         default: ;
      endcase
   end

   lcd_timer #(
      .CW      (CW),
      .RST_VAL (CW'(T_POWERON))
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_ld),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   assign lcd_rw = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_PWR_WAIT;
         init_idx  <= '0;
         req_byte  <= '0;
         req_rs_q  <= 1'b0;
         lcd_en    <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_data  <= '0;
         req_ready <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_PWR_WAIT: if (tmr_done) state <= ST_LOAD;
            ST_LOAD: begin
               if (!init_done) begin
                  lcd_rs   <= 1'b0;
                  lcd_data <= init_rom(init_idx);
               end else begin
                  lcd_rs   <= req_rs_q;
                  lcd_data <= req_byte;
               end
               state <= ST_SETUP;
            end
            ST_SETUP: if (tmr_done) begin
               lcd_en <= 1'b1;
               state  <= ST_PULSE;
            end
            ST_PULSE: if (tmr_done) begin
               lcd_en <= 1'b0;
               state  <= ST_HOLD;
            end
            ST_HOLD: if (tmr_done) state <= ST_EXEC;
            ST_EXEC: if (tmr_done) begin
               if (!init_done && init_idx != 3'(INIT_LEN - 1)) begin
                  init_idx <= init_idx + 3'd1;
                  state    <= ST_LOAD;
               end else begin
                  init_done <= 1'b1;
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            ST_IDLE: if (req_valid && req_ready) begin
               req_rs_q  <= req_rs;
               req_byte  <= req_data;
               req_ready <= 1'b0;
               state     <= ST_LOAD;
            end
            default: state <= ST_PWR_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl
//   Directed bench for lcd_ctrl with shortened timing. Outputs are sampled on
//   the falling clock edge; cyc counts falling edges so every interval below
//   is in whole clock cycles.
module tb_lcd_ctrl;

   localparam int T_POWERON = 20;
   localparam int T_AS      = 2;
   localparam int T_PW      = 4;
   localparam int T_AH      = 1;
   localparam int T_EXEC    = 8;
   localparam int T_CLEAR   = 30;
   localparam int LIM       = 200;

   // fall -> next rise inside init: hold + exec wait + LOAD + setup
   localparam int GAP_ORD   = T_AH + T_EXEC  + 1 + T_AS;   // 12
   localparam int GAP_CLR   = T_AH + T_CLEAR + 1 + T_AS;   // 34
   localparam int GAP_PWR   = T_POWERON + 1 + T_AS;        // 23 from reset release
   localparam int GAP_REQ   = 1 + 1 + T_AS;                // 4 from valid presented in IDLE
   localparam int RDY_ORD   = T_AH + T_EXEC;               // 9
   localparam int RDY_CLR   = T_AH + T_CLEAR;              // 31

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_rs = 1'b0;
   logic [7:0] req_data = 8'h00;
   logic       req_ready, init_done, lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;

   int nvec = 0, nerr = 0;
   int cyc = 0, last_chg = 0, ref_cyc = 0, rw_bad = 0;
   logic [8:0] prev = 9'h000;

   lcd_ctrl #(
      .T_POWERON (T_POWERON), .T_AS (T_AS), .T_PW (T_PW),
      .T_AH (T_AH), .T_EXEC (T_EXEC), .T_CLEAR (T_CLEAR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_rs    (req_rs),
      .req_data  (req_data),
      .req_ready (req_ready),
      .init_done (init_done),
      .lcd_data  (lcd_data),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_en    (lcd_en)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if ({lcd_rs, lcd_data} !== prev) begin
         last_chg = cyc;
         prev     = {lcd_rs, lcd_data};
      end
      if (lcd_rw !== 1'b0) rw_bad++;
   endtask

   // Waits for one enable pulse and checks its position, contents, width and hold.
   task automatic write_pulse(input string tag, input logic rs, input logic [7:0] d,
                              input int gap, input bit exact_setup);
      int n = 0;
      int rise;
      while (lcd_en !== 1'b1 && n < LIM) begin tick(); n++; end
      chk({tag, "_seen"}, 32'(lcd_en), 32'd1);
      rise = cyc;
      chk({tag, "_gap"}, rise - ref_cyc, gap);
      chk({tag, "_rs"}, 32'(lcd_rs), 32'(rs));
      chk({tag, "_data"}, 32'(lcd_data), 32'(d));
      if (exact_setup) chk({tag, "_setup"}, rise - last_chg, T_AS);
      n = 0;
      while (lcd_en === 1'b1 && n < LIM) begin tick(); n++; end
      chk({tag, "_width"}, n, T_PW);
      ref_cyc = cyc;
      repeat (T_AH) tick();
      chk({tag, "_hold"}, 32'(last_chg <= rise - T_AS), 32'd1);
   endtask

   task automatic wait_ready(input string tag, input int gap);
      int n = 0;
      while (req_ready !== 1'b1 && n < LIM) begin tick(); n++; end
      chk(tag, cyc - ref_cyc, gap);
   endtask

   task automatic send(input logic rs, input logic [7:0] d);
      req_valid = 1'b1; req_rs = rs; req_data = d;
      ref_cyc = cyc;
      tick();
      chk("accept_ready_low", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
   endtask

   task automatic run_init(input string tag);
      write_pulse({tag, "0"}, 1'b0, 8'h38, GAP_PWR, 1'b1);
      write_pulse({tag, "1"}, 1'b0, 8'h38, GAP_ORD, 1'b0);
      write_pulse({tag, "2"}, 1'b0, 8'h38, GAP_ORD, 1'b0);
      write_pulse({tag, "3"}, 1'b0, 8'h0C, GAP_ORD, 1'b1);
      write_pulse({tag, "4"}, 1'b0, 8'h01, GAP_ORD, 1'b1);
      chk({tag, "_done_early"}, 32'(init_done), 32'd0);
      write_pulse({tag, "5"}, 1'b0, 8'h06, GAP_CLR, 1'b1);
      wait_ready({tag, "_ready"}, RDY_ORD);
      chk({tag, "_done"}, 32'(init_done), 32'd1);
   endtask

   initial begin
      int n;
      // reset state
      repeat (3) tick();
      chk("rst_en",    32'(lcd_en),    32'd0);
      chk("rst_rs",    32'(lcd_rs),    32'd0);
      chk("rst_data",  32'(lcd_data),  32'h00);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_done",  32'(init_done), 32'd0);

      // 1: power-on wait and init sequence
      rst = 1'b0;
      ref_cyc = cyc;
      run_init("init");

      // 2: single data write
      send(1'b1, 8'h41);
      write_pulse("w41", 1'b1, 8'h41, GAP_REQ, 1'b1);
      wait_ready("w41_ready", RDY_ORD);

      // 3: clear, home, set-address commands
      send(1'b0, 8'h01);
      write_pulse("c01", 1'b0, 8'h01, GAP_REQ, 1'b1);
      wait_ready("c01_ready", RDY_CLR);
      send(1'b0, 8'h02);
      write_pulse("c02", 1'b0, 8'h02, GAP_REQ, 1'b1);
      wait_ready("c02_ready", RDY_CLR);
      send(1'b0, 8'h80);
      write_pulse("c80", 1'b0, 8'h80, GAP_REQ, 1'b1);
      wait_ready("c80_ready", RDY_ORD);

      // 5: valid held across two bytes
      req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h41;
      ref_cyc = cyc;
      tick();
      chk("b2b_accept1", 32'(req_ready), 32'd0);
      req_data = 8'h42;
      write_pulse("b2b41", 1'b1, 8'h41, GAP_REQ, 1'b1);
      wait_ready("b2b_ready1", RDY_ORD);
      ref_cyc = cyc;
      tick();
      chk("b2b_accept2", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      write_pulse("b2b42", 1'b1, 8'h42, GAP_REQ, 1'b1);
      wait_ready("b2b_ready2", RDY_ORD);

      // 6: reset in the middle of an enable pulse
      send(1'b1, 8'h43);
      n = 0;
      while (lcd_en !== 1'b1 && n < LIM) begin tick(); n++; end
      chk("mid_en_seen", 32'(lcd_en), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_en",    32'(lcd_en),    32'd0);
      chk("mid_rst_rs",    32'(lcd_rs),    32'd0);
      chk("mid_rst_data",  32'(lcd_data),  32'h00);
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_done",  32'(init_done), 32'd0);

      // 4: valid held from reset through init
      req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
      repeat (3) tick();
      rst = 1'b0;
      ref_cyc = cyc;
      run_init("reinit");
      ref_cyc = cyc;
      tick();
      chk("held_accept", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      write_pulse("w55", 1'b1, 8'h55, GAP_REQ, 1'b1);
      wait_ready("w55_ready", RDY_ORD);
      n = 0;
      repeat (40) begin
         tick();
         if (lcd_en === 1'b1) n++;
      end
      chk("no_extra_pulse", n, 0);
      chk("rw_low", rw_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
